// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the parametrised FIFO
//
// Purpose: default geometry and read-mode encoding for fifo_param.
package fifo_pkg;

  // Default geometry
  localparam int FIFO_DATA_SIZE_DEF = 8;
  localparam int FIFO_ADDR_SIZE_DEF = 3;

  // Read-mode encoding for the FWFT parameter
  localparam int FWFT_REGISTERED = 0;  // data_out registered on pop, 1-cycle latency
  localparam int FWFT_SHOW_AHEAD = 1;  // head word visible while non-empty

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - dual-port storage array for fifo_param
//
// Purpose: DATA_SIZE x 2**ADDR_SIZE array with a synchronous write port
//          and an asynchronous read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable (accepted push)
//   waddr  - write address (write pointer)
//   wdata  - write data
//   raddr  - read address (read pointer)
//   rdata  - read data, combinational from raddr
module fifo_ram #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds, pause and sticky error
//
// Purpose: single-clock FIFO between a producer and a consumer. fifo_pause
//          is the producer backpressure (hysteresis between af_thr/ae_thr).
// Ports:
//   clk, reset_L         - clock, asynchronous active-low reset
//   push, data_in        - write request and data
//   pop                  - read request
//   af_thr, ae_thr       - almost-full / almost-empty thresholds
//   err_clr              - clears the sticky fifo_error
//   data_out, valid_out  - read data and its qualifier (mode depends on FWFT)
//   data_count           - occupancy 0..DEPTH
//   fifo_full/empty      - occupancy flags
//   almost_full/empty    - threshold flags
//   fifo_error           - sticky overflow/underflow
//   fifo_pause           - producer backpressure
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE_DEF,
  parameter int ADDR_SIZE = FIFO_ADDR_SIZE_DEF,
  parameter int FWFT      = FWFT_REGISTERED
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   af_thr,
  input  logic [ADDR_SIZE:0]   ae_thr,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error,
  output logic                 fifo_pause
);

  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(2**ADDR_SIZE);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   count;
  logic [ADDR_SIZE:0]   count_nxt;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 push_acc;
  logic                 pop_acc;
  logic                 err_evt;

  // Flags are combinational from the registered count so they reflect a
  // transfer on the cycle after it is accepted.
  assign fifo_full    = (count == DEPTH);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= af_thr);
  assign almost_empty = (count != '0) && (count <= ae_thr);
  assign data_count   = count;

  // A pop on full frees a slot in the same cycle, so a concurrent push is taken.
  assign pop_acc  = pop & ~fifo_empty;
  assign push_acc = push & (~fifo_full | pop_acc);
  assign err_evt  = (push & ~push_acc) | (pop & fifo_empty);

  always_comb begin
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_error <= 1'b0;
      fifo_pause <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      // New error in the clear cycle keeps the flag set.
      fifo_error <= err_evt | (fifo_error & ~err_clr);
      // Hysteresis; set has priority if thresholds overlap.
      if (count_nxt >= af_thr) begin
        fifo_pause <= 1'b1;
      end else if (count_nxt <= ae_thr) begin
        fifo_pause <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FWFT_SHOW_AHEAD) begin : g_show_ahead
      assign data_out  = rd_data;
      assign valid_out = ~fifo_empty;
    end else begin : g_registered
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          data_out  <= '0;
          valid_out <= 1'b0;
        end else begin
          valid_out <= pop_acc;
          if (pop_acc) data_out <= rd_data;
        end
      end
    end
  endgenerate

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's small FIFO.
- Data width and depth are independent parameters. Occupancy count is full-range: depth 2**ADDR_SIZE, ADDR_SIZE+1 bit count.
- Adds programmable almost thresholds, pause with hysteresis, a sticky error with clear, and a selectable show-ahead (FWFT) read mode.
- Sits between a producer and a consumer; fifo_pause is the backpressure signal to the producer.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_SIZE, 3, pointer width; depth DEPTH = 2**ADDR_SIZE
FWFT, 0, 0 = registered read (1-cycle latency); 1 = show-ahead, head word visible while non-empty

Ports:
clk  in  1  single clock, all state on rising edge
reset_L  in  1  asynchronous, active-low reset
push  in  1  write request
pop  in  1  read request
data_in  in  DATA_SIZE  write data
af_thr  in  ADDR_SIZE+1  almost-full threshold (count >= af_thr)
ae_thr  in  ADDR_SIZE+1  almost-empty threshold (0 < count <= ae_thr)
err_clr  in  1  clears sticky fifo_error
data_out  out  DATA_SIZE  read data
valid_out  out  1  data_out holds a popped word (FWFT=0) / head valid (FWFT=1)
data_count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= af_thr
almost_empty  out  1  count != 0 and count <= ae_thr
fifo_error  out  1  sticky overflow/underflow flag
fifo_pause  out  1  producer backpressure with hysteresis

Behaviour:
Reset (reset_L low, asynchronous):
- Pointers, count, data_out, valid_out, fifo_error and fifo_pause all go to 0.
- Therefore fifo_empty=1, fifo_full=0, almost_full=0 (unless af_thr==0), almost_empty=0.
- Reset mid-operation discards all contents. Memory array contents are not reset.

Acceptance:
- pop_acc = pop & !fifo_empty.
- push_acc = push & (!fifo_full | pop_acc); push on full with a simultaneous pop is accepted.
- Push+pop on empty: push accepted, pop rejected (counts as underflow).

Pointers and count:
- wr_ptr and rd_ptr are ADDR_SIZE bits and wrap naturally from DEPTH-1 to 0.
- count +1 on push only, -1 on pop only, unchanged on both or neither.
- count never exceeds DEPTH and never underflows.

Flags:
- fifo_full, fifo_empty, almost_full and almost_empty are combinational from the registered count and the threshold inputs.
- They update the cycle after the accepted transfer.

Read path:
- FWFT=0: on pop_acc, data_out <= mem[rd_ptr] and valid_out <= 1 for one cycle. Otherwise valid_out <= 0 and data_out holds its last value.
- FWFT=1: data_out = mem[rd_ptr] and valid_out = !fifo_empty; pop_acc advances to the next word.
- Write-to-read: a word pushed into an empty FIFO is poppable the following cycle. No same-cycle bypass.

Error (fifo_error):
- Set on (push & !push_acc) or (pop & fifo_empty).
- Held until err_clr. A new error in the same cycle as err_clr wins, so the flag stays 1.
- Errors never corrupt pointers or count.

Pause (fifo_pause, registered, hysteresis):
- Set when next count >= af_thr.
- Cleared when next count <= ae_thr.
- Otherwise holds its value.
- If both conditions are true (misprogrammed af_thr <= ae_thr), set wins.

Thresholds:
- Sampled every cycle; changing them takes effect on flags immediately and on pause the next edge.

Decomposition:
- Package fifo_pkg holds default DATA_SIZE/ADDR_SIZE constants and the FWFT mode encoding constants.
- Sub-module fifo_ram: dual-port array, DATA_SIZE x DEPTH, synchronous write at wr_ptr on push_acc, asynchronous read at rd_ptr.
- fifo_param owns all control logic, flags and the read register.

Test Plan:
(All scenarios use DATA_SIZE=8, ADDR_SIZE=3, af_thr=6, ae_thr=2.)
- Fill/drain: push 0x10..0x17 (8 words) -> fifo_full=1, data_count=8. Pop 8 -> data_out 0x10..0x17 in order, each with valid_out=1 one cycle after pop (FWFT=0). End with fifo_empty=1, fifo_error=0.
- Overflow: on full, push 0xAA with pop=0 -> fifo_error=1, count stays 8, 0xAA never read. Then pulse err_clr -> fifo_error=0 next cycle.
- Simultaneous ops:
  - On full, push 0x55 + pop together -> count stays 8, oldest word out, 0x55 read last, no error.
  - On empty, push 0x33 + pop together -> count=1, fifo_error=1.
- Pause hysteresis: push to count 6 -> fifo_pause=1. Pop to 3 -> still 1. Pop to 2 -> 0. almost_empty=1 at counts 2 and 1, 0 at count 0.
- Wrap-around: 20 cycles of interleaved push/pop with count oscillating 1..5 -> pointers wrap past 7 and data order is preserved (scoreboard).
- FWFT=1 and reset: push 0x42 -> data_out=0x42 and valid_out=1 the next cycle, without pop. Assert reset_L low mid-stream (asynchronously) -> fifo_empty=1, data_count=0, valid_out=0, fifo_pause=0 immediately.
